// File: rtl/sau_odd16_mac.sv
// Serial multiple-constant MAC for the odd half of a 16-point DCT-II: 8 samples in, y[1..15] out.
// Define SAU_ODD16_ROUND_SHIFT_EN to round and arithmetic-shift the results by SHIFT.
module sau_odd16_mac #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned ACC_W = 28,
    parameter int unsigned SHIFT = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*ACC_W-1:0]   out_data
);

    if (ACC_W < IN_W + 9) begin : g_acc_w_check
        $error("ACC_W must be at least IN_W+9");
    end
    if (SHIFT < 1) begin : g_shift_check
        $error("SHIFT must be at least 1");
    end

    // Row r holds y[2r+1]; column n is the sample index.
    localparam int COEF [8][8] = '{
        '{90,  87,  80,  70,  57,  43,  25,   9},
        '{87,  57,   9, -43, -80, -90, -70, -25},
        '{80,   9, -70, -87, -25,  57,  90,  43},
        '{70, -43, -87,   9,  90,  25, -80, -57},
        '{57, -80, -25,  90,  -9, -87,  43,  70},
        '{43, -90,  57,  25, -87,  70,   9, -80},
        '{25, -70,  90, -80,  43,   9, -57,  87},
        '{ 9, -25,  43, -57,  70, -80,  87, -90}
    };

`ifdef SAU_ODD16_ROUND_SHIFT_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);
`endif

    typedef enum logic [0:0] {StAcc, StHold} state_e;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [ACC_W-1:0]   acc_q [8];
    logic [ACC_W-1:0]   acc_d [8];
    logic [8*ACC_W-1:0] out_q, out_d;

    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] p9, p25, p43, p57, p70, p80, p87, p90;

    function automatic logic [ACC_W-1:0] post(input logic [ACC_W-1:0] a);
`ifdef SAU_ODD16_ROUND_SHIFT_EN
        logic [ACC_W-1:0] s;
        s = a + RND;
        return ACC_W'($signed(s) >>> SHIFT);
`else
        return a;
`endif
    endfunction

    // Shared shift-add products for the eight coefficient magnitudes.
    always_comb begin
        x   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
        p9  = (x << 3) + x;
        p25 = (x << 4) + (x << 3) + x;
        p43 = (x << 5) + (x << 3) + (x << 1) + x;
        p57 = (x << 6) - (x << 3) + x;
        p70 = (x << 6) + (x << 2) + (x << 1);
        p80 = (x << 6) + (x << 4);
        p87 = (x << 6) + (x << 4) + (x << 3) - x;
        p90 = (x << 6) + (x << 4) + (x << 3) + (x << 1);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        out_d     = out_q;
        for (int r = 0; r < 8; r++) acc_d[r] = acc_q[r];
        in_ready  = (state_q == StAcc);
        out_valid = (state_q == StHold);

        unique case (state_q)
            StAcc: begin
                if (in_valid) begin
                    for (int r = 0; r < 8; r++) begin
                        unique case (COEF[r][idx_q])
                            9:       acc_d[r] = acc_q[r] + p9;
                            -9:      acc_d[r] = acc_q[r] - p9;
                            25:      acc_d[r] = acc_q[r] + p25;
                            -25:     acc_d[r] = acc_q[r] - p25;
                            43:      acc_d[r] = acc_q[r] + p43;
                            -43:     acc_d[r] = acc_q[r] - p43;
                            57:      acc_d[r] = acc_q[r] + p57;
                            -57:     acc_d[r] = acc_q[r] - p57;
                            70:      acc_d[r] = acc_q[r] + p70;
                            -70:     acc_d[r] = acc_q[r] - p70;
                            80:      acc_d[r] = acc_q[r] + p80;
                            -80:     acc_d[r] = acc_q[r] - p80;
                            87:      acc_d[r] = acc_q[r] + p87;
                            -87:     acc_d[r] = acc_q[r] - p87;
                            90:      acc_d[r] = acc_q[r] + p90;
                            -90:     acc_d[r] = acc_q[r] - p90;
                            default: acc_d[r] = acc_q[r];
                        endcase
                    end
                    idx_d = idx_q + 3'd1;
                    // Last sample: capture the completed sums so latency stays one cycle.
                    if (idx_q == 3'd7) begin
                        state_d = StHold;
                        for (int j = 0; j < 8; j++) out_d[j*ACC_W +: ACC_W] = post(acc_d[j]);
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAcc;
                    idx_d   = '0;
                    for (int r = 0; r < 8; r++) acc_d[r] = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAcc;
            idx_q   <= '0;
            out_q   <= '0;
            for (int r = 0; r < 8; r++) acc_q[r] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            for (int r = 0; r < 8; r++) acc_q[r] <= acc_d[r];
        end
    end

    assign out_data = out_q;

endmodule

// File: doc/sau_odd16_mac.md
Name: sau_odd16_mac

Overview:
- Sequential multiple-constant multiply-accumulate engine for the odd half of the 16-point DCT-II.
- Accepts the 8 odd-part butterfly inputs O[n] = x[n] - x[15-n] serially, one per handshake, and accumulates all 8 odd coefficients y[k], k = 1,3,...,15.
- Sits after the 16-point butterfly stage and time-shares one shift-add coefficient set {9,25,43,57,70,80,87,90} across the 8 rows.

Parameters:
- IN_W, 18: signed input sample width.
- ACC_W, 28: signed accumulator and output width. Must be >= IN_W+9 because the maximum absolute row sum is 461 < 2^9.
- SHIFT, 7: arithmetic right shift applied when ROUND_SHIFT_EN is defined; ignored otherwise. Must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  sample O[n] present
- in_ready  out  1  block can accept a sample
- in_data  in  IN_W  signed sample O[n], n = internal index 0..7
- out_valid  out  1  results y[1..15] held and valid
- out_ready  in  1  consumer accepts the results
- out_data  out  8*ACC_W  signed results; slice j (bits [j*ACC_W +: ACC_W]) = y[2j+1]

Behaviour:
- Reset and synchronicity:
  - One clock. Reset is synchronous and active-high.
  - In any cycle with rst=1, at the next edge: state=ACC, idx=0, all 8 accumulators=0, out_valid=0, in_ready=1, out_data=0.
  - Reset overrides every other event, including a mid-block reset or a reset during HOLD. A partial block is discarded.
- Coefficient matrix C[k][n], rows k=1..15 odd, columns n=0..7:
  - k1: 90 87 80 70 57 43 25 9
  - k3: 87 57 9 -43 -80 -90 -70 -25
  - k5: 80 9 -70 -87 -25 57 90 43
  - k7: 70 -43 -87 9 90 25 -80 -57
  - k9: 57 -80 -25 90 -9 -87 43 70
  - k11: 43 -90 57 25 -87 70 9 -80
  - k13: 25 -70 90 -80 43 9 -57 87
  - k15: 9 -25 43 -57 70 -80 87 -90
- Products: formed by shift-add only. No `*` operator and no DSP inference. Negative entries are handled by subtracting from the accumulator.
- Product and accumulate widths: products are sign-extended to ACC_W before the add. The accumulate wraps modulo 2^ACC_W, with no saturation; this cannot occur at legal ACC_W.
- States: ACC and HOLD.
  - ACC:
    - in_ready=1, out_valid=0.
    - On in_valid && in_ready, at the next edge: acc[k] += C[k][idx]*in_data for every k, and idx increments.
    - When the accepted sample has idx=7, the next state is HOLD and idx wraps to 0.
    - in_valid=0 causes a stall. Nothing changes and no timeout applies.
  - HOLD:
    - in_ready=0, out_valid=1, out_data stable and driven from registers.
    - in_valid is ignored.
    - On out_ready=1, at the next edge: accumulators clear to 0, state returns to ACC, idx=0.
- Latency and throughput:
  - 8th sample accepted at edge t; out_valid=1 in the cycle after t.
  - Minimum block period is 9 cycles (8 accept cycles + 1 HOLD cycle with out_ready=1).
  - No overlap between blocks: in_ready is low for the whole of HOLD.
- Simultaneous events:
  - HOLD with out_ready=1 and in_valid=1: the sample is not consumed, because in_ready=0.
  - out_ready while in ACC: no effect.
- out_data outside HOLD: holds the last registered value. It is only meaningful while out_valid=1.

Optional Feature:
- Macro: SAU_ODD16_ROUND_SHIFT_EN.
- Defined: out_data slice j = (acc[j] + 2^(SHIFT-1)) >>> SHIFT, arithmetic, sign-extended to ACC_W. It is registered at the ACC->HOLD transition, so latency is unchanged.
- Undefined: out_data slice j = acc[j], raw and unrounded. The SHIFT parameter is unused.

Test Plan:
- Impulse: inputs 1,0,0,0,0,0,0,0 with in_valid held high.
  - Required: out_valid exactly 1 cycle after the 8th accept.
  - Required y[1..15] = 90,87,80,70,57,43,25,9.
- All ones: 8 samples of +1.
  - Required y = 461,-155,97,-73,59,-53,47,-43.
- Extreme input: 8 samples of -131072.
  - Required y[1] = -60424192 and y[3] = 20316160, with no wrap at ACC_W=28.
- Backpressure and stalls:
  - in_valid toggles 1,0,1 between samples; out_ready is held 0 for 5 cycles in HOLD.
  - Required: results unchanged, in_ready=0 throughout HOLD, and the extra in_valid is not consumed.
  - Required: after out_ready=1, in_ready=1 on the next cycle and the next block with all ones again gives 461.
- Reset mid-block: rst=1 after 4 accepted samples, then the impulse block.
  - Required: outputs exactly the impulse result, with no residue from the partial block.
- With SAU_ODD16_ROUND_SHIFT_EN and SHIFT=7:
  - Inputs 128,0,...,0. Required y[1]=90 and y[15]=9.
  - Inputs 1,0,...,0. Required y[1]=1 ((90+64)>>7) and y[15]=0.
